// File: rtl/lite_burst_converter_pkg.sv
// Shared constants and beat-count helper for the lite-to-burst converter.
// The constants describe the default 512-bit-in / 64-bit-out configuration;
// the helper functions take the geometry as arguments so that any
// parameterisation of the top level can reuse them.
package lite_burst_converter_pkg;

    localparam int unsigned IN_DATA_WIDTH  = 32'd512;
    localparam int unsigned OUT_DATA_WIDTH = 32'd64;

    // Output words per full-width input payload.
    localparam int unsigned BW = IN_DATA_WIDTH / OUT_DATA_WIDTH;
    // Bytes carried by one output word.
    localparam int unsigned OB = OUT_DATA_WIDTH / 32'd8;
    // Width of the beat counter; never narrower than one bit.
    localparam int unsigned CNT_W = (BW > 32'd1) ? $clog2(BW) : 32'd1;

    // Counter width for an arbitrary number of words per payload.
    function automatic int unsigned cnt_width(input int unsigned bw);
        int unsigned w;
        if (bw > 32'd1) begin
            w = $clog2(bw);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    // Stored burst length (beats minus one) for a message of 2^size bytes.
    // Messages smaller than one output word still occupy one beat, and
    // messages larger than the payload register are clamped to all words.
    function automatic int unsigned beat_len(input int unsigned size,
                                             input int unsigned ob,
                                             input int unsigned bw);
        int unsigned bytes;
        int unsigned beats;
        bytes = 32'd1 << size;
        beats = bytes / ob;
        if (beats < 32'd1) begin
            beats = 32'd1;
        end else if (beats > bw) begin
            beats = bw;
        end else begin
            beats = beats;
        end
        return beats - 32'd1;
    endfunction

endpackage

// File: rtl/lite_burst_converter_word_serializer.sv
// Dynamic-length parallel-in / serial-out word serializer.
// A full payload and a burst length are loaded in one cycle; the words are
// then presented one at a time, lowest word first, from a dedicated output
// register so the consumer never sees a combinational path from the load
// side. The unit is idle (ready) whenever it holds no burst.
module word_serializer
    import lite_burst_converter_pkg::*;
#(
    parameter int unsigned word_width_p = 32'd64,
    parameter int unsigned num_words_p  = 32'd8,
    parameter int unsigned cnt_width_p  = 32'd3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [num_words_p-1:0][word_width_p-1:0]   load_data,
    input  logic [cnt_width_p-1:0]                     load_len,
    input  logic                                       load_v,
    output logic                                       ready,
    output logic [word_width_p-1:0]                    word,
    output logic                                       word_v,
    input  logic                                       yumi
);

    logic [num_words_p-1:0][word_width_p-1:0] data_r;
    logic [cnt_width_p-1:0]                   len_r;
    logic [cnt_width_p-1:0]                   cnt_r;
    logic [word_width_p-1:0]                  word_r;
    logic                                     v_r;

    logic [cnt_width_p-1:0]                   cnt_next_s;
    logic                                     last_s;
    logic                                     load_s;
    logic                                     advance_s;

    // Decode load / advance conditions and the next word index.
    always_comb begin
        cnt_next_s = cnt_r + cnt_width_p'(1);
        last_s     = (cnt_r == len_r);
        load_s     = load_v && !v_r;
        advance_s  = v_r && yumi;
    end

    // Burst state: capture on load, step the counter on each consumed word,
    // and return to idle with a cleared counter after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            len_r  <= '0;
            cnt_r  <= '0;
            word_r <= '0;
            v_r    <= 1'b0;
        end else if (load_s) begin
            data_r <= load_data;
            len_r  <= load_len;
            cnt_r  <= '0;
            word_r <= load_data[0];
            v_r    <= 1'b1;
        end else if (advance_s) begin
            if (last_s) begin
                cnt_r  <= '0;
                word_r <= '0;
                v_r    <= 1'b0;
            end else begin
                cnt_r  <= cnt_next_s;
                word_r <= data_r[cnt_next_s];
                v_r    <= 1'b1;
            end
        end else begin
            data_r <= data_r;
            len_r  <= len_r;
            cnt_r  <= cnt_r;
            word_r <= word_r;
            v_r    <= v_r;
        end
    end

    assign ready  = !v_r;
    assign word   = word_r;
    assign word_v = v_r;

endmodule

// File: rtl/lite_burst_converter.sv
// Lite-to-burst message converter.
// Accepts a whole message (header + full-width payload) in one handshake and
// re-issues it as a single header beat plus a burst of narrow data words.
// The header sits in a one-entry buffer; the payload sits in a serializer.
// A new message is accepted only once both of them have fully drained, so
// the input ready depends on registered state alone.
module lite_burst_converter
    import lite_burst_converter_pkg::*;
#(
    parameter int unsigned in_data_width_p  = 32'd512,
    parameter int unsigned out_data_width_p = 32'd64,
    parameter int unsigned header_width_p   = 32'd64,
    parameter int unsigned msg_type_width_p = 32'd4,
    parameter int unsigned size_width_p     = 32'd3,
    parameter logic [(1<<msg_type_width_p)-1:0] payload_mask_p = '0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [header_width_p-1:0]    in_header_i,
    input  logic [msg_type_width_p-1:0]  in_msg_type_i,
    input  logic [size_width_p-1:0]      in_size_i,
    input  logic [in_data_width_p-1:0]   in_data_i,
    input  logic                         in_v_i,
    output logic                         in_ready_and_o,
    output logic [header_width_p-1:0]    out_header_o,
    output logic                         out_header_v_o,
    input  logic                         out_header_ready_and_i,
    output logic [out_data_width_p-1:0]  out_data_o,
    output logic                         out_data_v_o,
    input  logic                         out_data_ready_and_i
);

    localparam int unsigned bw_lp    = in_data_width_p / out_data_width_p;
    localparam int unsigned ob_lp    = out_data_width_p / 32'd8;
    localparam int unsigned cnt_w_lp = cnt_width(bw_lp);

    // One-entry header buffer.
    logic [header_width_p-1:0] hdr_r;
    logic                      hdr_full_r;

    logic                      ser_ready_s;
    logic                      ser_v_s;
    logic [out_data_width_p-1:0] ser_word_s;

    logic                      ready_s;
    logic                      accept_s;
    logic                      has_data_s;
    logic                      load_v_s;
    logic                      hdr_deq_s;
    logic                      data_yumi_s;
    logic [cnt_w_lp-1:0]       len_s;

    // Accept decode, payload presence and burst length for the incoming message.
    always_comb begin
        has_data_s  = payload_mask_p[in_msg_type_i];
        ready_s     = !hdr_full_r && ser_ready_s;
        accept_s    = in_v_i && ready_s;
        load_v_s    = accept_s && has_data_s;
        len_s       = cnt_w_lp'(beat_len(32'(in_size_i), ob_lp, bw_lp));
        hdr_deq_s   = hdr_full_r && out_header_ready_and_i;
        data_yumi_s = ser_v_s && out_data_ready_and_i;
    end

    // Header buffer: fill on accept, drain on header handshake. Accept is
    // gated by the empty flag, so fill and drain never coincide.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_r      <= '0;
            hdr_full_r <= 1'b0;
        end else if (accept_s) begin
            hdr_r      <= in_header_i;
            hdr_full_r <= 1'b1;
        end else if (hdr_deq_s) begin
            hdr_r      <= hdr_r;
            hdr_full_r <= 1'b0;
        end else begin
            hdr_r      <= hdr_r;
            hdr_full_r <= hdr_full_r;
        end
    end

    word_serializer #(
        .word_width_p (out_data_width_p),
        .num_words_p  (bw_lp),
        .cnt_width_p  (cnt_w_lp)
    ) u_word_serializer (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .load_data (in_data_i),
        .load_len  (len_s),
        .load_v    (load_v_s),
        .ready     (ser_ready_s),
        .word      (ser_word_s),
        .word_v    (ser_v_s),
        .yumi      (data_yumi_s)
    );

    assign in_ready_and_o = ready_s;
    assign out_header_o   = hdr_r;
    assign out_header_v_o = hdr_full_r;
    assign out_data_o     = ser_word_s;
    assign out_data_v_o   = ser_v_s;

endmodule

// File: tb/tb_lite_burst_converter.sv
// Scoreboard bench for lite_burst_converter: stimulus pushes expected header
// and data words; a negedge monitor pops and compares on every handshake.
module tb_lite_burst_converter;

    logic         clk_i = 1'b1;
    logic         reset_n_i;
    logic [63:0]  in_header_i;
    logic [3:0]   in_msg_type_i;
    logic [2:0]   in_size_i;
    logic [511:0] in_data_i;
    logic         in_v_i;
    logic         in_ready_and_o;
    logic [63:0]  out_header_o;
    logic         out_header_v_o;
    logic         out_header_ready_and_i;
    logic [63:0]  out_data_o;
    logic         out_data_v_o;
    logic         out_data_ready_and_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dcount   = 0;
    int hdr_cyc  = 0;

    logic [63:0] hdr_q[$];
    logic [63:0] data_q[$];
    logic [63:0] dval_q[$];
    int          dcyc_q[$];

    lite_burst_converter #(
        .payload_mask_p (16'h0002)
    ) dut (
        .clk_i                  (clk_i),
        .reset_n_i              (reset_n_i),
        .in_header_i            (in_header_i),
        .in_msg_type_i          (in_msg_type_i),
        .in_size_i              (in_size_i),
        .in_data_i              (in_data_i),
        .in_v_i                 (in_v_i),
        .in_ready_and_o         (in_ready_and_o),
        .out_header_o           (out_header_o),
        .out_header_v_o         (out_header_v_o),
        .out_header_ready_and_i (out_header_ready_and_i),
        .out_data_o             (out_data_o),
        .out_data_v_o           (out_data_v_o),
        .out_data_ready_and_i   (out_data_ready_and_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: cyc numbers the upcoming posedge; handshakes seen here complete on it.
    always @(negedge clk_i) begin
        logic [63:0] e;
        cyc++;
        if (out_header_v_o && out_header_ready_and_i) begin
            hdr_cyc = cyc;
            if (hdr_q.size() == 0) begin
                chk("hdr_unexpected", out_header_o, 64'hx);
            end else begin
                e = hdr_q.pop_front();
                chk("hdr_value", out_header_o, e);
            end
        end
        if (out_data_v_o && out_data_ready_and_i) begin
            dcount++;
            dcyc_q.push_back(cyc);
            dval_q.push_back(out_data_o);
            if (data_q.size() == 0) begin
                chk("data_unexpected", out_data_o, 64'hx);
            end else begin
                e = data_q.pop_front();
                chk("data_word", out_data_o, e);
            end
        end
    end

    function automatic logic [511:0] pat(input logic [7:0] seed);
        logic [511:0] p;
        for (int k = 0; k < 64; k++) begin
            p[k*8 +: 8] = seed + 8'(k);
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [63:0] hdr, input logic [3:0] typ, input logic [2:0] size,
                        input logic [511:0] data, input int nbeats, output int acc);
        int n;
        n = 0;
        in_header_i   = hdr;
        in_msg_type_i = typ;
        in_size_i     = size;
        in_data_i     = data;
        in_v_i        = 1'b1;
        while (!in_ready_and_o && n < 200) begin
            tick();
            n++;
        end
        chk("accept_timeout", 64'(n >= 200), 64'd0);
        hdr_q.push_back(hdr);
        for (int k = 0; k < nbeats; k++) begin
            data_q.push_back(data[k*64 +: 64]);
        end
        @(posedge clk_i);
        acc = cyc;
        #1;
        in_v_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((hdr_q.size() != 0 || data_q.size() != 0 || !in_ready_and_o) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n >= 300), 64'd0);
    endtask

    task automatic wait_words(input int target);
        int n;
        n = 0;
        while (dcount < target && n < 200) begin
            tick();
            n++;
        end
        chk("words_timeout", 64'(dcount >= target), 64'd1);
    endtask

    typedef struct {
        logic [2:0] size;
        int         beats;
    } size_vec_t;

    initial begin
        int a1;
        int a2;
        int d0;
        int seen;
        int span;
        logic [63:0] hold;
        size_vec_t vecs[5];

        reset_n_i              = 1'b0;
        in_header_i            = 64'd0;
        in_msg_type_i          = 4'd0;
        in_size_i              = 3'd0;
        in_data_i              = 512'd0;
        in_v_i                 = 1'b0;
        out_header_ready_and_i = 1'b1;
        out_data_ready_and_i   = 1'b1;

        // Reset state.
        tick();
        chk("rst_in_ready", 64'(in_ready_and_o), 64'd1);
        chk("rst_hdr_v",    64'(out_header_v_o), 64'd0);
        chk("rst_data_v",   64'(out_data_v_o), 64'd0);
        chk("rst_hdr",      out_header_o, 64'd0);
        chk("rst_data",     out_data_o, 64'd0);
        tick();
        reset_n_i = 1'b1;
        tick();

        // Header-only message.
        seen = 0;
        send(64'hAAAA_0000_0000_0001, 4'd0, 3'd6, pat(8'h11), 0, a1);
        for (int i = 0; i < 6; i++) begin
            if (out_data_v_o) seen = 1;
            tick();
        end
        chk("hdr_only_no_data", 64'(seen), 64'd0);
        chk("hdr_only_latency", 64'(hdr_cyc), 64'(a1 + 1));
        wait_drain();
        chk("hdr_only_ready", 64'(in_ready_and_o), 64'd1);

        // Full 64-byte burst, 8 consecutive words.
        dcyc_q.delete();
        dval_q.delete();
        send(64'hBBBB_0000_0000_0002, 4'd1, 3'd6, pat(8'h01), 8, a1);
        wait_drain();
        chk("burst_count", 64'(dcyc_q.size()), 64'd8);
        span = (dcyc_q.size() >= 8) ? (dcyc_q[7] - dcyc_q[0]) : -1;
        chk("burst_span", 64'(span), 64'd7);
        chk("burst_first_lat", 64'(dcyc_q.size() > 0 ? dcyc_q[0] : -1), 64'(a1 + 1));
        chk("burst_word0", dval_q.size() > 0 ? dval_q[0] : 64'd0, 64'h0807060504030201);
        chk("burst_word7", dval_q.size() > 7 ? dval_q[7] : 64'd0, 64'h403f3e3d3c3b3a39);

        // Size table: beats hand-computed for 8-byte words, 8-word payload.
        vecs[0] = '{3'd3, 1};
        vecs[1] = '{3'd4, 2};
        vecs[2] = '{3'd0, 1};
        vecs[3] = '{3'd5, 4};
        vecs[4] = '{3'd7, 8};
        for (int v = 0; v < 5; v++) begin
            d0 = dcount;
            send(64'hC000 + 64'(v), 4'd1, vecs[v].size, pat(8'h20 + 8'(v * 16)), vecs[v].beats, a1);
            wait_drain();
            chk("size_beats", 64'(dcount - d0), 64'(vecs[v].beats));
        end

        // Backpressure mid-burst, header held until data drains.
        out_header_ready_and_i = 1'b0;
        d0 = dcount;
        send(64'hDDDD_0000_0000_0004, 4'd1, 3'd6, pat(8'h80), 8, a1);
        wait_words(d0 + 3);
        out_data_ready_and_i = 1'b0;
        hold = out_data_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_word_stable", out_data_o, hold);
            chk("bp_valid_held",  64'(out_data_v_o), 64'd1);
            chk("bp_in_ready",    64'(in_ready_and_o), 64'd0);
        end
        chk("bp_word3", hold, pat(8'h80) >> 192);
        out_data_ready_and_i = 1'b1;
        wait_words(d0 + 8);
        tick();
        chk("bp_hdr_pending_ready", 64'(in_ready_and_o), 64'd0);
        chk("bp_hdr_still_valid",   64'(out_header_v_o), 64'd1);
        out_header_ready_and_i = 1'b1;
        tick();
        chk("bp_ready_after_hdr", 64'(in_ready_and_o), 64'd1);
        wait_drain();

        // Back-to-back 8-byte messages.
        send(64'hEEEE_0000_0000_0005, 4'd1, 3'd3, pat(8'h90), 1, a1);
        send(64'hEEEE_0000_0000_0006, 4'd1, 3'd3, pat(8'hA0), 1, a2);
        chk("b2b_gap", 64'((a2 - a1) >= 2), 64'd1);
        wait_drain();

        // Reset at word 3 of 8, then a fresh burst.
        d0 = dcount;
        send(64'hFFFF_0000_0000_0007, 4'd1, 3'd6, pat(8'hB0), 8, a1);
        wait_words(d0 + 3);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_data_v", 64'(out_data_v_o), 64'd0);
        chk("mid_rst_hdr_v",  64'(out_header_v_o), 64'd0);
        chk("mid_rst_data",   out_data_o, 64'd0);
        hdr_q.delete();
        data_q.delete();
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready_and_o), 64'd1);
        dval_q.delete();
        d0 = dcount;
        send(64'h1234_5678_9ABC_DEF0, 4'd1, 3'd6, pat(8'hC1), 8, a1);
        wait_drain();
        chk("post_rst_beats", 64'(dcount - d0), 64'd8);
        chk("post_rst_word0", dval_q.size() > 0 ? dval_q[0] : 64'd0, 64'hC8C7C6C5C4C3C2C1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
